// File: rtl/omap_wr_biu.sv
// Output-feature-map write BIU: buffers merger results in a small FIFO and issues
// one arbiter write beat per result at base + idx*ADDR_STEP. Optional macro: OMAP_BIU_PERF_EN.
module omap_wr_biu #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_STEP  = 1,
  parameter int CNT_W      = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    out_ch,
  input  logic [15:0]   map_size,
  input  logic [AW-1:0] omap_base_addr,
  input  logic          conv_start,
  output logic          omap_done,
  output logic          omap_busy,
  output logic          omap_biu2arb_req,
  output logic [AW-1:0] omap_biu2arb_addr,
  output logic [DW-1:0] omap_biu2arb_data,
  output logic          omap_biu2arb_vld,
  input  logic          omap_biu2arb_rdy,
  input  logic [DW-1:0] map_merger2omap_biu_data,
  input  logic          map_merger2omap_biu_vld,
  output logic          map_merger2omap_biu_rdy
`ifdef OMAP_BIU_PERF_EN
  ,
  output logic [31:0]   omap_stall_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] total, in_cnt, out_cnt, total_calc;
  logic [23:0]      prod_full;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    mem [FIFO_DEPTH];
  logic [PW:0]      wr_ptr, rd_ptr;
  logic             fifo_empty, fifo_full;
  logic             start_ok, in_fire, out_fire, last_in, last_out;

  assign prod_full  = {8'b0, map_size} * {16'b0, out_ch};
  assign total_calc = CNT_W'(prod_full);

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign start_ok = conv_start && (state == IDLE);
  assign in_fire  = map_merger2omap_biu_vld && map_merger2omap_biu_rdy;
  assign out_fire = omap_biu2arb_vld && omap_biu2arb_rdy;
  assign last_in  = in_fire && (in_cnt == total - CNT_W'(1));
  assign last_out = out_fire && (out_cnt == total - CNT_W'(1));

  // rdy is built from registered state only, so a full FIFO blocks input even when popping
  assign map_merger2omap_biu_rdy = (state == RUN) && !fifo_full && (in_cnt < total);
  assign omap_biu2arb_vld  = !fifo_empty;
  assign omap_biu2arb_data = mem[rd_ptr[PW-1:0]];
  assign omap_biu2arb_addr = addr_q;
  assign omap_biu2arb_req  = (state == RUN) || (state == DRAIN);
  assign omap_busy         = (state != IDLE);
  assign omap_done         = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (conv_start) state_nxt = (total_calc == '0) ? DONE : RUN;
      RUN: begin
        if (last_in && last_out) state_nxt = DONE;
        else if (last_in)        state_nxt = DRAIN;
      end
      DRAIN: if (last_out) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      total   <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      addr_q  <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        total   <= total_calc;
        in_cnt  <= '0;
        out_cnt <= '0;
        addr_q  <= omap_base_addr;
      end else begin
        if (in_fire) in_cnt <= in_cnt + CNT_W'(1);
        if (out_fire) begin
          out_cnt <= out_cnt + CNT_W'(1);
          addr_q  <= addr_q + AW'(ADDR_STEP);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (in_fire) begin
        mem[wr_ptr[PW-1:0]] <= map_merger2omap_biu_data;
        wr_ptr <= wr_ptr + (PW+1)'(1);
      end
      if (out_fire) rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

`ifdef OMAP_BIU_PERF_EN
  logic stall_evt;
  assign stall_evt = (omap_biu2arb_vld && !omap_biu2arb_rdy) ||
                     ((state == RUN) && map_merger2omap_biu_vld && !map_merger2omap_biu_rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               omap_stall_cnt <= '0;
    else if (start_ok)                        omap_stall_cnt <= '0;
    else if (stall_evt && omap_stall_cnt != '1) omap_stall_cnt <= omap_stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_omap_wr_biu.sv
// Directed self-checking bench for omap_wr_biu (ADDR_STEP=4, FIFO_DEPTH=4).
module tb_omap_wr_biu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  out_ch = '0;
  logic [15:0] map_size = '0;
  logic [31:0] omap_base_addr = '0;
  logic        conv_start = 1'b0;
  logic        omap_done, omap_busy, omap_biu2arb_req, omap_biu2arb_vld;
  logic [31:0] omap_biu2arb_addr, omap_biu2arb_data;
  logic        omap_biu2arb_rdy = 1'b0;
  logic [31:0] map_merger2omap_biu_data = '0;
  logic        map_merger2omap_biu_vld = 1'b0;
  logic        map_merger2omap_biu_rdy;
`ifdef OMAP_BIU_PERF_EN
  logic [31:0] omap_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  omap_wr_biu #(.DW(32), .AW(32), .FIFO_DEPTH(4), .ADDR_STEP(4), .CNT_W(24)) dut (
    .clk(clk), .rst_n(rst_n), .out_ch(out_ch), .map_size(map_size),
    .omap_base_addr(omap_base_addr), .conv_start(conv_start),
    .omap_done(omap_done), .omap_busy(omap_busy),
    .omap_biu2arb_req(omap_biu2arb_req), .omap_biu2arb_addr(omap_biu2arb_addr),
    .omap_biu2arb_data(omap_biu2arb_data), .omap_biu2arb_vld(omap_biu2arb_vld),
    .omap_biu2arb_rdy(omap_biu2arb_rdy),
    .map_merger2omap_biu_data(map_merger2omap_biu_data),
    .map_merger2omap_biu_vld(map_merger2omap_biu_vld),
    .map_merger2omap_biu_rdy(map_merger2omap_biu_rdy)
`ifdef OMAP_BIU_PERF_EN
    , .omap_stall_cnt(omap_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired got timeout exp finish");
    $fatal(1);
  end

  // Returns at the falling edge after the start pulse has been sampled.
  task automatic pulse_start(input logic [31:0] base, input logic [15:0] ms, input logic [7:0] oc);
    @(negedge clk);
    omap_base_addr = base; map_size = ms; out_ch = oc; conv_start = 1'b1;
    @(negedge clk);
    conv_start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (omap_biu2arb_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", omap_biu2arb_req); end
    checks++; if (omap_biu2arb_vld !== 1'b0) begin errors++; $display("FAIL rst_vld got %b exp 0", omap_biu2arb_vld); end
    checks++; if (omap_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", omap_done); end
    checks++; if (omap_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", omap_busy); end
    checks++; if (map_merger2omap_biu_rdy !== 1'b0) begin errors++; $display("FAIL rst_mrdy got %b exp 0", map_merger2omap_biu_rdy); end
    checks++; if (omap_biu2arb_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", omap_biu2arb_addr); end
    checks++; if (omap_biu2arb_data !== 32'h0) begin errors++; $display("FAIL rst_data got %h exp 0", omap_biu2arb_data); end
  endtask

  task automatic test_basic_stream;
    int mi = 0, oi = 0, cyc = 0;
    pulse_start(32'h1000, 16'd4, 8'd2);
    checks++; if (omap_biu2arb_req !== 1'b1) begin errors++; $display("FAIL t1_req_start got %b exp 1", omap_biu2arb_req); end
    checks++; if (omap_busy !== 1'b1) begin errors++; $display("FAIL t1_busy got %b exp 1", omap_busy); end
    checks++; if (omap_biu2arb_vld !== 1'b0) begin errors++; $display("FAIL t1_vld_empty got %b exp 0", omap_biu2arb_vld); end
    while (oi < 8 && cyc < 200) begin
      map_merger2omap_biu_vld  = (mi < 8);
      map_merger2omap_biu_data = 32'hA000_0000 + mi;
      omap_biu2arb_rdy = 1'b1;
      if (map_merger2omap_biu_vld && map_merger2omap_biu_rdy) mi++;
      if (omap_biu2arb_vld && omap_biu2arb_rdy) begin
        checks++; if (omap_biu2arb_addr !== 32'h1000 + 4*oi) begin errors++; $display("FAIL t1_addr beat %0d got %h exp %h", oi, omap_biu2arb_addr, 32'h1000 + 4*oi); end
        checks++; if (omap_biu2arb_data !== 32'hA000_0000 + oi) begin errors++; $display("FAIL t1_data beat %0d got %h exp %h", oi, omap_biu2arb_data, 32'hA000_0000 + oi); end
        oi++;
      end
      @(negedge clk); cyc++;
    end
    map_merger2omap_biu_vld = 1'b0; omap_biu2arb_rdy = 1'b0;
    checks++; if (oi !== 8) begin errors++; $display("FAIL t1_beats got %0d exp 8", oi); end
    checks++; if (omap_done !== 1'b1) begin errors++; $display("FAIL t1_done got %b exp 1", omap_done); end
    checks++; if (omap_biu2arb_req !== 1'b0) begin errors++; $display("FAIL t1_req_end got %b exp 0", omap_biu2arb_req); end
    @(negedge clk);
    checks++; if (omap_done !== 1'b0) begin errors++; $display("FAIL t1_done_pulse got %b exp 0", omap_done); end
    checks++; if (omap_busy !== 1'b0) begin errors++; $display("FAIL t1_idle got %b exp 0", omap_busy); end
  endtask

  task automatic test_backpressure;
    int mi = 0, oi = 0, cyc = 0;
    pulse_start(32'h0, 16'd4, 8'd2);
    while (oi < 8 && cyc < 200) begin
      map_merger2omap_biu_vld  = (mi < 8);
      map_merger2omap_biu_data = 32'hB000_0000 + mi;
      omap_biu2arb_rdy = (cyc >= 10);
      if (cyc == 10) begin
        checks++; if (mi !== 4) begin errors++; $display("FAIL t2_accepts got %0d exp 4", mi); end
        checks++; if (map_merger2omap_biu_rdy !== 1'b0) begin errors++; $display("FAIL t2_full_rdy got %b exp 0", map_merger2omap_biu_rdy); end
        checks++; if (omap_biu2arb_data !== 32'hB000_0000) begin errors++; $display("FAIL t2_hold_data got %h exp b0000000", omap_biu2arb_data); end
        checks++; if (omap_biu2arb_addr !== 32'h0) begin errors++; $display("FAIL t2_hold_addr got %h exp 0", omap_biu2arb_addr); end
      end
      if (map_merger2omap_biu_vld && map_merger2omap_biu_rdy) mi++;
      if (omap_biu2arb_vld && omap_biu2arb_rdy) begin
        checks++; if (omap_biu2arb_addr !== 4*oi) begin errors++; $display("FAIL t2_addr beat %0d got %h exp %h", oi, omap_biu2arb_addr, 4*oi); end
        checks++; if (omap_biu2arb_data !== 32'hB000_0000 + oi) begin errors++; $display("FAIL t2_data beat %0d got %h exp %h", oi, omap_biu2arb_data, 32'hB000_0000 + oi); end
        oi++;
      end
      @(negedge clk); cyc++;
    end
    map_merger2omap_biu_vld = 1'b0; omap_biu2arb_rdy = 1'b0;
    checks++; if (oi !== 8) begin errors++; $display("FAIL t2_beats got %0d exp 8", oi); end
    checks++; if (omap_done !== 1'b1) begin errors++; $display("FAIL t2_done got %b exp 1", omap_done); end
    @(negedge clk);
  endtask

  task automatic test_zero_len;
    int req_seen = 0;
    pulse_start(32'h5000, 16'd0, 8'd5);
    checks++; if (omap_done !== 1'b1) begin errors++; $display("FAIL t3_done got %b exp 1", omap_done); end
    checks++; if (map_merger2omap_biu_rdy !== 1'b0) begin errors++; $display("FAIL t3_mrdy got %b exp 0", map_merger2omap_biu_rdy); end
    for (int i = 0; i < 4; i++) begin
      if (omap_biu2arb_req || omap_biu2arb_vld) req_seen++;
      @(negedge clk);
    end
    checks++; if (req_seen !== 0) begin errors++; $display("FAIL t3_req_vld got %0d cycles exp 0", req_seen); end
    checks++; if (omap_busy !== 1'b0) begin errors++; $display("FAIL t3_idle got %b exp 0", omap_busy); end
  endtask

  task automatic test_restart_ignored;
    int mi = 0, oi = 0, cyc = 0, early_done = 0;
    pulse_start(32'h3000, 16'd4, 8'd2);
    while (oi < 8 && cyc < 200) begin
      conv_start = (cyc == 3);
      if (cyc == 3) begin omap_base_addr = 32'h4000; map_size = 16'd1; out_ch = 8'd1; end
      map_merger2omap_biu_vld  = (mi < 8);
      map_merger2omap_biu_data = 32'hC000_0000 + mi;
      omap_biu2arb_rdy = 1'b1;
      if (omap_done) early_done++;
      if (map_merger2omap_biu_vld && map_merger2omap_biu_rdy) mi++;
      if (omap_biu2arb_vld && omap_biu2arb_rdy) begin
        checks++; if (omap_biu2arb_addr !== 32'h3000 + 4*oi) begin errors++; $display("FAIL t4_addr beat %0d got %h exp %h", oi, omap_biu2arb_addr, 32'h3000 + 4*oi); end
        checks++; if (omap_biu2arb_data !== 32'hC000_0000 + oi) begin errors++; $display("FAIL t4_data beat %0d got %h exp %h", oi, omap_biu2arb_data, 32'hC000_0000 + oi); end
        oi++;
      end
      @(negedge clk); cyc++;
    end
    conv_start = 1'b0; map_merger2omap_biu_vld = 1'b0; omap_biu2arb_rdy = 1'b0;
    checks++; if (oi !== 8) begin errors++; $display("FAIL t4_beats got %0d exp 8", oi); end
    checks++; if (early_done !== 0) begin errors++; $display("FAIL t4_early_done got %0d exp 0", early_done); end
    checks++; if (omap_done !== 1'b1) begin errors++; $display("FAIL t4_done got %b exp 1", omap_done); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int mi = 0, oi = 0, cyc = 0;
    pulse_start(32'h1000, 16'd4, 8'd2);
    while (oi < 3 && cyc < 200) begin
      map_merger2omap_biu_vld  = (mi < 8);
      map_merger2omap_biu_data = 32'hD000_0000 + mi;
      omap_biu2arb_rdy = 1'b1;
      if (map_merger2omap_biu_vld && map_merger2omap_biu_rdy) mi++;
      if (omap_biu2arb_vld && omap_biu2arb_rdy) oi++;
      @(negedge clk); cyc++;
    end
    rst_n = 1'b0;
    #1;
    checks++; if (omap_biu2arb_req !== 1'b0) begin errors++; $display("FAIL t5_req got %b exp 0", omap_biu2arb_req); end
    checks++; if (omap_biu2arb_vld !== 1'b0) begin errors++; $display("FAIL t5_vld got %b exp 0", omap_biu2arb_vld); end
    checks++; if (omap_busy !== 1'b0) begin errors++; $display("FAIL t5_busy got %b exp 0", omap_busy); end
    checks++; if (omap_biu2arb_addr !== 32'h0) begin errors++; $display("FAIL t5_addr got %h exp 0", omap_biu2arb_addr); end
    checks++; if (omap_biu2arb_data !== 32'h0) begin errors++; $display("FAIL t5_data got %h exp 0", omap_biu2arb_data); end
    map_merger2omap_biu_vld = 1'b0; omap_biu2arb_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (omap_done !== 1'b0) begin errors++; $display("FAIL t5_no_done got %b exp 0", omap_done); end
    mi = 0; oi = 0; cyc = 0;
    pulse_start(32'h2000, 16'd2, 8'd1);
    while (oi < 2 && cyc < 200) begin
      map_merger2omap_biu_vld  = (mi < 2);
      map_merger2omap_biu_data = 32'hE000_0000 + mi;
      omap_biu2arb_rdy = 1'b1;
      if (map_merger2omap_biu_vld && map_merger2omap_biu_rdy) mi++;
      if (omap_biu2arb_vld && omap_biu2arb_rdy) begin
        checks++; if (omap_biu2arb_addr !== 32'h2000 + 4*oi) begin errors++; $display("FAIL t5_addr beat %0d got %h exp %h", oi, omap_biu2arb_addr, 32'h2000 + 4*oi); end
        checks++; if (omap_biu2arb_data !== 32'hE000_0000 + oi) begin errors++; $display("FAIL t5_data beat %0d got %h exp %h", oi, omap_biu2arb_data, 32'hE000_0000 + oi); end
        oi++;
      end
      @(negedge clk); cyc++;
    end
    map_merger2omap_biu_vld = 1'b0; omap_biu2arb_rdy = 1'b0;
    checks++; if (omap_done !== 1'b1) begin errors++; $display("FAIL t5_done got %b exp 1", omap_done); end
    @(negedge clk);
  endtask

`ifdef OMAP_BIU_PERF_EN
  task automatic test_perf_stall;
    int mi = 0, oi = 0, cyc = 0, stalls = 0;
    pulse_start(32'h1000, 16'd4, 8'd2);
    checks++; if (omap_stall_cnt !== 32'd0) begin errors++; $display("FAIL t6_clear got %0d exp 0", omap_stall_cnt); end
    while (oi < 8 && cyc < 200) begin
      map_merger2omap_biu_vld  = (mi < 8);
      map_merger2omap_biu_data = 32'hF000_0000 + mi;
      omap_biu2arb_rdy = ((cyc % 2) == 0);
      if ((omap_biu2arb_vld && !omap_biu2arb_rdy) ||
          (map_merger2omap_biu_vld && !map_merger2omap_biu_rdy)) stalls++;
      if (map_merger2omap_biu_vld && map_merger2omap_biu_rdy) mi++;
      if (omap_biu2arb_vld && omap_biu2arb_rdy) begin
        checks++; if (omap_biu2arb_data !== 32'hF000_0000 + oi) begin errors++; $display("FAIL t6_data beat %0d got %h exp %h", oi, omap_biu2arb_data, 32'hF000_0000 + oi); end
        oi++;
      end
      @(negedge clk); cyc++;
    end
    map_merger2omap_biu_vld = 1'b0; omap_biu2arb_rdy = 1'b0;
    checks++; if (omap_done !== 1'b1) begin errors++; $display("FAIL t6_done got %b exp 1", omap_done); end
    checks++; if (omap_stall_cnt !== 32'(stalls)) begin errors++; $display("FAIL t6_stall_cnt got %0d exp %0d", omap_stall_cnt, stalls); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic_stream();
    test_backpressure();
    test_zero_len();
    test_restart_ignored();
    test_reset_mid();
`ifdef OMAP_BIU_PERF_EN
    test_perf_stall();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
